mux9_scan_sequencer: RTL and testbench

- Drives the `sel` input of the adjacent 9-to-1 16-bit data mux.
- Walks the enabled channels in ascending order, one conversion per start, and captures the mux output at each step.
- Presents each captured word downstream on a valid/ready stream, tagged with its channel number and a last flag.
- Sits between the control/CSR logic (start, channel mask) and the downstream sample consumer.

---
 rtl/mux9_scan_sequencer_pkg.sv | 18 +
 rtl/mux9_next_chan.sv | 24 ++
 rtl/mux9_scan_sequencer.sv | 109 ++++++++++
 tb/tb_mux9_scan_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mux9_scan_sequencer_pkg.sv
// rtl/mux9_scan_sequencer_pkg.sv - shared constants and state type for the mux9 scan sequencer
package mux9_scan_sequencer_pkg;

  localparam int WIDTH = 16;
  localparam int NCH   = 9;
  localparam int SEL_W = 4;

  // Out-of-range select: the mux answers with all-ones while we are not scanning.
  localparam logic [SEL_W-1:0] IDLE_SEL = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    OUT  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/mux9_next_chan.sv
// rtl/mux9_next_chan.sv - priority finder for the next enabled channel above the current one
module mux9_next_chan
  import mux9_scan_sequencer_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  input  logic             first,
  output logic [SEL_W-1:0] next_idx,
  output logic             none
);

  // Descending walk so the lowest qualifying index is the one left standing.
  always_comb begin
    next_idx = '0;
    none     = 1'b1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (SEL_W'(i) > cur))) begin
        next_idx = SEL_W'(i);
        none     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux9_scan_sequencer.sv
// rtl/mux9_scan_sequencer.sv - walks enabled mux channels and streams each captured sample
module mux9_scan_sequencer
  import mux9_scan_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [NCH-1:0]   chan_en,
  output logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] mux_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_chan,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_next;
  logic [NCH-1:0]   mask_q;
  logic [NCH-1:0]   find_mask;
  logic             find_first;
  logic [SEL_W-1:0] find_idx;
  logic             find_none;

  // One finder serves both searches: from the live mask in IDLE, from the latched mask afterwards.
  assign find_mask  = (state == IDLE) ? chan_en : mask_q;
  assign find_first = (state == IDLE);

  mux9_next_chan u_next_chan (
    .mask     (find_mask),
    .cur      (sel),
    .first    (find_first),
    .next_idx (find_idx),
    .none     (find_none)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (chan_en != '0) ? SEL : FIN;
        end
      end
      SEL:     state_next = OUT;
      OUT: begin
        if (out_ready) begin
          state_next = out_last ? FIN : SEL;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel       <= IDLE_SEL;
      mask_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state_next == FIN);
      case (state)
        IDLE: begin
          if (start) begin
            mask_q <= chan_en;
            if (!find_none) begin
              sel <= find_idx;
            end
          end
        end
        SEL: begin
          // sel has been stable for a full cycle, so the mux output is settled here.
          out_data  <= mux_dout;
          out_chan  <= sel;
          out_valid <= 1'b1;
          out_last  <= find_none;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            sel       <= out_last ? IDLE_SEL : find_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux9_scan_sequencer.sv
// tb/tb_mux9_scan_sequencer.sv - randomized self-checking bench against a channel-list reference model
module tb_mux9_scan_sequencer;
  import mux9_scan_sequencer_pkg::*;

  logic             clk = 1'b0;
  logic             resetn;
  logic             start;
  logic [NCH-1:0]   chan_en;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] mux_dout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_chan;
  logic             out_last;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] mux_in [0:NCH-1];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mux_dout = (sel < SEL_W'(NCH)) ? mux_in[sel] : {WIDTH{1'b1}};

  mux9_scan_sequencer dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .chan_en   (chan_en),
    .sel       (sel),
    .mux_dout  (mux_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_sel", 32'(sel), 32'(IDLE_SEL));
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_chan", 32'(out_chan), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
  endtask

  // mode 0: ready high; 1: random ready; 2: 5-cycle stall on first beat; 3: ready high plus mid-scan disturbance
  task automatic run_scan(input logic [NCH-1:0] mask, input int mode);
    int               exp_q[$];
    int               n;
    int               idx;
    int               k;
    int               stall;
    bit               seen;
    bit               got_done;
    logic [WIDTH-1:0] hd;
    logic [SEL_W-1:0] hc;
    logic             hl;

    exp_q.delete();
    for (int c = 0; c < NCH; c++) if (mask[c]) exp_q.push_back(c);
    n = exp_q.size();
    idx = 0; k = 0; stall = 0; seen = 0; got_done = 0;
    hd = '0; hc = '0; hl = 1'b0;

    chan_en = mask;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int it = 0; it < 400; it++) begin
      k++;
      chk("sel_range", 32'((sel < SEL_W'(NCH)) || (sel == IDLE_SEL)), 32'd1);
      if (k == 1) begin
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("first_sel", 32'(sel), (n > 0) ? 32'(exp_q[0]) : 32'(IDLE_SEL));
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (idx < n) begin
            hd = mux_in[exp_q[idx]];
            hc = SEL_W'(exp_q[idx]);
            hl = (idx == n - 1);
            if (idx == 0) chk("first_valid_cycle", 32'(k), 32'd2);
          end else begin
            chk("extra_beat", 32'd1, 32'd0);
          end
          chk("beat_chan", 32'(out_chan), 32'(hc));
          chk("beat_data", 32'(out_data), 32'(hd));
          chk("beat_last", 32'(out_last), 32'(hl));
        end else begin
          chk("hold_chan", 32'(out_chan), 32'(hc));
          chk("hold_data", 32'(out_data), 32'(hd));
          chk("hold_last", 32'(out_last), 32'(hl));
        end
      end else if (seen) begin
        chk("valid_dropped", 32'd0, 32'd1);
        seen = 1'b0;
      end
      if (done) begin
        if (mode == 0 || mode == 3) chk("done_cycle", 32'(k), 32'(2 * n + 1));
        chk("beats_at_done", 32'(idx), 32'(n));
        chk("sel_at_done", 32'(sel), 32'(IDLE_SEL));
        chk("valid_at_done", 32'(out_valid), 32'd0);
        got_done = 1'b1;
        break;
      end
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (idx == 0 && seen && stall < 5) begin
            out_ready = 1'b0;
            stall++;
            mux_in[exp_q[0]] = ~mux_in[exp_q[0]];
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
      if (mode == 3 && k == 3) begin
        start = 1'b1;
        chan_en = ~mask;
      end else begin
        start = 1'b0;
      end
      if (out_valid && out_ready) begin
        idx++;
        seen = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("scan_finished", 32'(got_done), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    chan_en = '0;
    out_ready = 1'b0;
    for (int c = 0; c < NCH; c++) mux_in[c] = WIDTH'(c);
    repeat (2) @(negedge clk);
    check_reset_values();
    resetn = 1'b1;
    @(negedge clk);

    run_scan(9'h1FF, 0);
    run_scan(9'b1_0000_0101, 0);

    for (int c = 0; c < NCH; c++) mux_in[c] = WIDTH'($urandom);
    run_scan(9'h003, 2);

    run_scan(9'h000, 0);

    for (int c = 0; c < NCH; c++) mux_in[c] = WIDTH'($urandom);
    run_scan(9'h0A6, 3);

    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < NCH; c++) mux_in[c] = WIDTH'($urandom);
      run_scan(NCH'($urandom), 1);
    end

    // Abort with a beat pending, then confirm a clean rescan.
    out_ready = 1'b0;
    chan_en = 9'h1A5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < 10 && !out_valid; w++) @(negedge clk);
    chk("valid_before_abort", 32'(out_valid), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check_reset_values();
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'(done), 32'd0);
      chk("no_valid_after_abort", 32'(out_valid), 32'd0);
    end
    for (int c = 0; c < NCH; c++) mux_in[c] = WIDTH'($urandom);
    run_scan(9'h1A5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
